btn_debounce_pulse: RTL and testbench

//  Front-panel button conditioner feeding the single-cycle CPU's step clock and reset.
//  - Synchronises one raw, bouncy push-button input.
//  - Filters bounce with a stability counter.
//  - Emits a clean level plus one-cycle press/release pulses, so one press gives

---
 rtl/btn_debounce_pulse_pkg.sv | 32 +++
 rtl/btn_debounce_pulse_sync_2ff.sv | 32 +++
 rtl/btn_debounce_pulse.sv | 179 +++++++++++++++++
 tb/tb_btn_debounce_pulse.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/btn_debounce_pulse_pkg.sv
// ============================================================================
// Module : btn_debounce_pulse_pkg
// Brief  : Shared FSM encoding, board defaults and config check for the button
//          conditioner.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package btn_debounce_pulse_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CHK_HI = 2'd1,
        S_HELD   = 2'd2,
        S_CHK_LO = 2'd3
    } btn_state_t;

    // Defaults sized for a 50 MHz board clock.
    localparam int DEF_DB_CYCLES    = 1_000_000;
    localparam int DEF_CNT_W        = 20;
    localparam int DEF_REPEAT_DELAY = 50_000_000;
    localparam int DEF_REPEAT_RATE  = 10_000_000;

    function automatic bit cfg_ok(input longint db, input longint cw,
                                  input longint dly, input longint rate);
        return (db >= 1) && (cw >= 1) && (cw <= 32) &&
               ((db - 1) < (longint'(1) << cw)) && (dly >= 1) && (rate >= 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce_pulse_sync_2ff.sv
// ============================================================================
// Module : sync_2ff
// Brief  : Two-flop synchroniser for a single asynchronous input pin.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/btn_debounce_pulse.sv
// ============================================================================
// Module : btn_debounce_pulse
// Brief  : Synchronise, debounce and edge-pulse one push-button. Define
//          BTN_AUTOREPEAT_EN to add held-button auto-repeat presses.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module btn_debounce_pulse
    import btn_debounce_pulse_pkg::*;
#(
    parameter int DB_CYCLES    = DEF_DB_CYCLES,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_rel
);

    generate
        if (!cfg_ok(DB_CYCLES, CNT_W, REPEAT_DELAY, REPEAT_RATE)) begin : g_cfg_bad
            $error("btn_debounce_pulse: invalid DB_CYCLES/CNT_W/REPEAT configuration");
        end
    endgenerate

    // Entering CHK_* already counts as the first stable sample, so the last
    // count value before acceptance is DB_CYCLES-2.
    localparam bit             DB_ONE  = (DB_CYCLES == 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'((DB_CYCLES >= 2) ? (DB_CYCLES - 2) : 0);

    logic btn_s;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_raw),
        .q     (btn_s)
    );

    btn_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              rel_q, rel_d;

`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX + 1) : 1;
    localparam logic [RPT_W-1:0] RPT_FIRST_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             first_q, first_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        rpt_d   = rpt_q;
        first_d = first_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (btn_s) begin
                    cnt_d = '0;
                    if (DB_ONE) begin
                        state_d = S_HELD;
                        level_d = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        state_d = S_CHK_HI;
                    end
                end
            end
            S_CHK_HI: begin
                if (!btn_s) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = S_HELD;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HELD: begin
                if (!btn_s) begin
                    cnt_d = '0;
                    if (DB_ONE) begin
                        state_d = S_IDLE;
                        level_d = 1'b0;
                        rel_d   = 1'b1;
                    end else begin
                        state_d = S_CHK_LO;
                    end
                end
            end
            S_CHK_LO: begin
                if (btn_s) begin
                    state_d = S_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    rel_d   = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase

`ifdef BTN_AUTOREPEAT_EN
        // Repeat count advances only while settled in HELD; CHK_LO holds it.
        if (press_d) begin
            rpt_d   = '0;
            first_d = 1'b1;
        end else if (state_q == S_HELD && btn_s) begin
            if (rpt_q == (first_q ? RPT_FIRST_LAST : RPT_RATE_LAST)) begin
                rpt_d   = '0;
                first_d = 1'b0;
                press_d = 1'b1;
            end else begin
                rpt_d = rpt_q + 1'b1;
            end
        end else if (state_d == S_IDLE) begin
            rpt_d   = '0;
            first_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rpt_q   <= '0;
            first_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
`ifdef BTN_AUTOREPEAT_EN
            rpt_q   <= rpt_d;
            first_q <= first_d;
`endif
        end
    end

    assign btn_level = level_q;
    assign btn_press = press_q;
    assign btn_rel   = rel_q;

endmodule

`default_nettype wire

// File: tb/tb_btn_debounce_pulse.sv
// ============================================================================
// Module : tb_btn_debounce_pulse
// Brief  : Scoreboard bench for btn_debounce_pulse (directed cases + random
//          bounce), honours BTN_AUTOREPEAT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_btn_debounce_pulse;

    localparam int DB    = 4;
    localparam int DELAY = 10;
    localparam int RATE  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_raw = 1'b0;
    logic btn_level, btn_press, btn_rel;

    btn_debounce_pulse #(
        .DB_CYCLES    (DB),
        .CNT_W        (8),
        .REPEAT_DELAY (DELAY),
        .REPEAT_RATE  (RATE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .btn_press (btn_press),
        .btn_rel   (btn_rel)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit is_press;
    } ev_t;

    ev_t expq[$];
    int  cyc = 0;
    int  n_cmp = 0;
    int  n_bad = 0;
    int  press_cnt = 0;
    int  rel_cnt = 0;
    int  last_press_cyc = -1;
    int  last_rel_cyc = -1;

    // Reference: the input seen by the filter is the pin two edges late; the
    // level flips once DB consecutive samples disagree with it.
    bit m_s1, m_s2, m_level, m_first;
    int m_run, m_rc;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0; m_rc = 0; m_first = 1;
    endfunction

    function automatic void model_step(input bit raw);
        bit bs;
        int prev_run;
        bs = m_s2;
        m_s2 = m_s1;
        m_s1 = raw;
        prev_run = m_run;
        if (bs != m_level) begin
            m_run++;
            if (m_run == DB) begin
                m_level = bs;
                m_run = 0;
                expq.push_back('{cyc, bs});
                m_rc = 0;
                m_first = 1;
            end
        end else begin
            m_run = 0;
`ifdef BTN_AUTOREPEAT_EN
            if (m_level && prev_run == 0) begin
                m_rc++;
                if (m_rc == (m_first ? DELAY : RATE)) begin
                    expq.push_back('{cyc, 1'b1});
                    m_rc = 0;
                    m_first = 0;
                end
            end
`endif
        end
    endfunction

    task automatic drive(input bit v, input int n);
        btn_raw = v;
        repeat (n) begin
            @(posedge clk);
            cyc++;
            if (rst_n) model_step(btn_raw);
            else model_reset();
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        expq.delete();
        model_reset();
        drive(btn_raw, n);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT pulses.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_press", btn_press, 0);
            check("reset_rel", btn_rel, 0);
            check("reset_level", btn_level, 0);
        end else begin
            while (expq.size() > 0 && expq[0].cyc < cyc) begin
                check(expq[0].is_press ? "missed_press" : "missed_rel", 0, 1);
                void'(expq.pop_front());
            end
            if (btn_press || btn_rel) begin
                if (btn_press) begin press_cnt++; last_press_cyc = cyc; end
                if (btn_rel)   begin rel_cnt++;   last_rel_cyc = cyc;   end
                if (expq.size() == 0 || expq[0].cyc != cyc) begin
                    check("unexpected_pulse", {btn_press, btn_rel}, 0);
                end else begin
                    check("pulse_press", btn_press, expq[0].is_press);
                    check("pulse_rel", btn_rel, !expq[0].is_press);
                    void'(expq.pop_front());
                end
            end
            check("level", btn_level, m_level);
        end
    end

    int p0, r0, c0, exp_p;

    initial begin
        model_reset();
        // 1: reset with button held, then press 6 cycles after release
        btn_raw = 1'b1;
        #1;
        do_reset(3);
        drive(1, 8);
        check("t1_press_cycle", last_press_cyc, 6);
        check("t1_press_count", press_cnt, 1);
        check("t1_level", btn_level, 1);

        // 4-prep / 2: release fully, then short bounce
        drive(0, 12);
        p0 = press_cnt; r0 = rel_cnt;
        drive(1, 1); drive(0, 1); drive(1, 1); drive(0, 1); drive(1, 1);
        drive(0, 10);
        check("t2_no_press", press_cnt, p0);
        check("t2_no_rel", rel_cnt, r0);
        check("t2_level", btn_level, 0);

        // 3: held press with a short dropout
        drive(1, 10);
        r0 = rel_cnt;
        drive(0, 2);
        drive(1, 10);
        check("t3_no_rel", rel_cnt, r0);
        check("t3_level", btn_level, 1);

        // 4: clean release
        c0 = cyc;
        drive(0, 10);
        check("t4_rel_cycle", last_rel_cyc, c0 + 6);
        check("t4_level", btn_level, 0);

        // 5: reset in CHK_HI with cnt=2
        p0 = press_cnt;
        drive(1, 5);
        do_reset(2);
        check("t5_no_press", press_cnt, p0);
        drive(1, 8);
        check("t5_press_cycle", last_press_cyc, 6);
        check("t5_press_count", press_cnt, p0 + 1);

        // 6: held 30 cycles after acceptance at cycle 6
        drive(0, 12);
        do_reset(2);
        p0 = press_cnt;
        drive(1, 36);
        @(negedge clk);
        #1;
`ifdef BTN_AUTOREPEAT_EN
        exp_p = 8;
`else
        exp_p = 1;
`endif
        check("t6_press_count", press_cnt - p0, exp_p);
        drive(0, 12);

        // Random bounce with occasional reset
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) do_reset($urandom_range(1, 3));
            drive(1'($urandom_range(0, 1)), $urandom_range(1, 2 * DB + 3));
        end
        drive(1, 40);
        drive(0, 20);
        check("final_queue_empty", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
